// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN streaming stages: default widths, the packer
// state encoding and a saturating counter helper.
package bnn_pkg;

  localparam int DIN_W  = 32;
  localparam int PACK_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bnn_word_fifo.sv
// Show-ahead synchronous word FIFO shared by the BNN stages; head word is
// visible on dout whenever not empty, and dout reads zero when empty.
module bnn_word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_pop;
  logic         do_push;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/conv_pack.sv
// Binarizes conv results against a threshold, packs them LSB-first into words
// and buffers them for a valid/ready consumer. CONV_PACK_POPCNT_EN adds 'ones'.
module conv_pack
  import bnn_pkg::*;
#(
  parameter int DIN_W      = bnn_pkg::DIN_W,
  parameter int PACK_W     = bnn_pkg::PACK_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic signed [DIN_W-1:0] din,
  input  logic                    ivalid,
  input  logic                    idone,
  input  logic signed [DIN_W-1:0] threshold,
  output logic [PACK_W-1:0]       dout,
  output logic                    ovalid,
  input  logic                    oready,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        words,
  output logic                    overflow
`ifdef CONV_PACK_POPCNT_EN
  ,
  output logic [CNT_W-1:0]        ones
`endif
);

  localparam int IDX_W = $clog2(PACK_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [PACK_W-1:0] shift;
  logic [PACK_W-1:0] merged;
  logic [PACK_W-1:0] pend_word;
  logic [IDX_W-1:0]  idx;
  logic              pend_push;
  logic              bin_bit;
  logic              take;
  logic              wrap;
  logic              flush_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              accept;
  logic              drop;

  assign bin_bit = (din >= threshold);
  assign take    = (state == PACK) && ivalid && !start;
  assign wrap    = take && (idx == IDX_LAST);

  // A flush pushes whatever the frame left behind, counting this cycle's bit,
  // unless that bit already completed a full word.
  assign flush_push = (state == PACK) && idone && !start && !wrap && (take || (idx != '0));

  assign ovalid = !fifo_empty;
  assign pop    = ovalid && oready;
  assign accept = pend_push && (!fifo_full || pop);
  assign drop   = pend_push && fifo_full && !pop;

  always_comb begin
    merged = shift;
    if (take) merged[idx] = bin_bit;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PACK;
      PACK:    if (start) state_nxt = PACK;
               else if (idone) state_nxt = FLUSH;
      FLUSH:   state_nxt = start ? PACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completed or flushed words wait one cycle in pend_word, so frame_done
  // lines up with the push of the last word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shift      <= '0;
      idx        <= '0;
      pend_push  <= 1'b0;
      pend_word  <= '0;
      frame_done <= 1'b0;
      words      <= '0;
      overflow   <= 1'b0;
    end else begin
      pend_push  <= wrap || flush_push;
      frame_done <= (state == PACK) && idone && !start;
      if (wrap || flush_push) pend_word <= merged;

      if (start || wrap || ((state == PACK) && idone)) begin
        shift <= '0;
        idx   <= '0;
      end else if (take) begin
        shift <= merged;
        idx   <= idx + 1'b1;
      end

      if (start)       words <= '0;
      else if (accept) words <= sat_inc(words);

      if (start)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

`ifdef CONV_PACK_POPCNT_EN
  always_ff @(posedge clk) begin
    if (!rstn)                ones <= '0;
    else if (start)           ones <= '0;
    else if (take && bin_bit) ones <= sat_inc(ones);
  end
`endif

  bnn_word_fifo #(
    .W     (PACK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (pend_push),
    .din   (pend_word),
    .pop   (pop),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_conv_pack.sv
// Bench for conv_pack: compare-boundary table, directed frame sequences and
// randomized frames checked against a queue-based packing model.
module tb_conv_pack;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic signed [31:0] din;
  logic               ivalid;
  logic               idone;
  logic signed [31:0] threshold;
  logic [31:0]        dout;
  logic               ovalid;
  logic               oready;
  logic               frame_done;
  logic [15:0]        words;
  logic               overflow;
`ifdef CONV_PACK_POPCNT_EN
  logic [15:0]        ones;
`endif

  always #5 clk = ~clk;

  conv_pack #(
    .DIN_W      (32),
    .PACK_W     (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .din        (din),
    .ivalid     (ivalid),
    .idone      (idone),
    .threshold  (threshold),
    .dout       (dout),
    .ovalid     (ovalid),
    .oready     (oready),
    .frame_done (frame_done),
    .words      (words),
    .overflow   (overflow)
`ifdef CONV_PACK_POPCNT_EN
    ,
    .ones       (ones)
`endif
  );

  int          total = 0;
  int          bad = 0;
  int          ready_pct = 100;
  bit          model_en = 1'b1;
  logic [31:0] exp_q[$];
  bit          cur_bits[$];
  bit          in_frame = 1'b0;
  int          m_words = 0;
  int          m_ones = 0;
  bit          m_overflow = 1'b0;

  typedef struct {
    int          d;
    int          thr;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Output scoreboard: every accepted handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rstn && ovalid && oready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_word: got 0x%0h expected no word", dout);
      end else begin
        checkOutput("word", dout, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    oready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic modelPush();
    logic [31:0] w = '0;
    for (int i = 0; i < cur_bits.size(); i++) w = w + (32'(cur_bits[i]) << i);
    if (exp_q.size() >= DEPTH) m_overflow = 1'b1;
    else begin
      exp_q.push_back(w);
      if (m_words < 65535) m_words++;
    end
    cur_bits.delete();
  endtask

  task automatic applyStimulus(input bit s, input bit iv, input bit id, input int d, input int thr);
    start = s; ivalid = iv; idone = id; din = d; threshold = thr;
    if (model_en) begin
      if (s) begin
        in_frame = 1'b1;
        cur_bits.delete();
        m_words = 0; m_ones = 0; m_overflow = 1'b0;
      end else if (in_frame) begin
        if (iv) begin
          bit b;
          b = (longint'(d) >= longint'(thr));
          cur_bits.push_back(b);
          if (b) m_ones++;
          if (cur_bits.size() == 32) modelPush();
        end
        if (id) begin
          if (cur_bits.size() > 0) modelPush();
          in_frame = 1'b0;
        end
      end
    end
    tick();
    start = 1'b0; ivalid = 1'b0; idone = 1'b0;
  endtask

  task automatic doReset();
    rstn = 1'b0; start = 1'b0; ivalid = 1'b0; idone = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    exp_q.delete();
    cur_bits.delete();
    in_frame = 1'b0; m_words = 0; m_ones = 0; m_overflow = 1'b0;
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_dout"}, dout, 0);
    checkOutput({name, "_ovalid"}, ovalid, 0);
    checkOutput({name, "_frame_done"}, frame_done, 0);
    checkOutput({name, "_words"}, words, 0);
    checkOutput({name, "_overflow"}, overflow, 0);
`ifdef CONV_PACK_POPCNT_EN
    checkOutput({name, "_ones"}, ones, 0);
`endif
  endtask

  task automatic waitFrame(input string name);
    int n = 0;
    while (!frame_done && n < 20) begin
      tick();
      n++;
    end
    checkOutput({name, "_frame_done"}, frame_done, 1);
    tick();
    checkOutput({name, "_done_pulse"}, frame_done, 0);
  endtask

  task automatic drainWait(input string name);
    int n = 0;
    ready_pct = 100;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, "_drained"}, exp_q.size(), 0);
    tick();
    checkOutput({name, "_ovalid_low"}, ovalid, 0);
    checkOutput({name, "_dout_zero"}, dout, 0);
  endtask

  task automatic frameCounts(input string name);
    checkOutput({name, "_words"}, words, m_words);
    checkOutput({name, "_overflow"}, overflow, m_overflow);
`ifdef CONV_PACK_POPCNT_EN
    checkOutput({name, "_ones"}, ones, m_ones);
`endif
  endtask

  initial begin
    vecs[0] = '{5, 0, 32'h1};
    vecs[1] = '{-5, 0, 32'h0};
    vecs[2] = '{100, 100, 32'h1};
    vecs[3] = '{99, 100, 32'h0};
    vecs[4] = '{int'(32'h7FFF_FFFF), int'(32'h8000_0000), 32'h1};
    vecs[5] = '{int'(32'h8000_0000), 1, 32'h0};
    vecs[6] = '{int'(32'h0001_0000), int'(32'h0000_FFFF), 32'h1};
    vecs[7] = '{int'(32'h0000_FFFF), int'(32'h0001_0000), 32'h0};
    vecs[8] = '{-1, -1, 32'h1};
    vecs[9] = '{-2, -1, 32'h0};

    oready = 1'b1; din = '0; threshold = '0;
    doReset();
    checkReset("reset");

    // One-bit frames exercise the signed compare edges; the bit lands in bit 0.
    model_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].exp_word);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, vecs[i].d, vecs[i].thr);
      waitFrame($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_words", i), words, 1);
    end
    drainWait("vec");
    model_en = 1'b1;

    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) applyStimulus(0, 1, 0, (i % 2 == 0) ? 5 : -5, 0);
    applyStimulus(0, 0, 1, 0, 0);
    waitFrame("basic");
    frameCounts("basic");
    drainWait("basic");

    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 100, 100);
    applyStimulus(0, 0, 1, 0, 0);
    waitFrame("partial");
    frameCounts("partial");
    drainWait("partial");

    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) applyStimulus(0, 1, 0, i * 3 - 40, 0);
    applyStimulus(0, 1, 1, 7, 0);
    waitFrame("simul");
    frameCounts("simul");
    drainWait("simul");

    // Five words into a four-deep FIFO with no consumer: the fifth is lost.
    ready_pct = 0;
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 160; i++) applyStimulus(0, 1, 0, int'($urandom_range(20)) - 10, 0);
    applyStimulus(0, 0, 1, 0, 0);
    waitFrame("bp");
    frameCounts("bp");
    checkOutput("bp_ovalid_held", ovalid, 1);
    drainWait("bp");

    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 9, 0);
    doReset();
    checkReset("midreset");
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) applyStimulus(0, 1, 0, ((i / 4) % 2 == 0) ? 1 : -1, 0);
    applyStimulus(0, 1, 1, -1, 0);
    waitFrame("postreset");
    frameCounts("postreset");
    drainWait("postreset");

    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 9, 0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, (i % 3 == 0) ? 4 : -4, 0);
    applyStimulus(0, 0, 1, 0, 0);
    waitFrame("restart");
    frameCounts("restart");
    drainWait("restart");

    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) applyStimulus(0, 1, 0, (i < 17) ? 1 : -1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    waitFrame("popcnt");
    checkOutput("popcnt_words", words, 2);
`ifdef CONV_PACK_POPCNT_EN
    checkOutput("popcnt_ones", ones, 17);
`endif
    drainWait("popcnt");

    ready_pct = 75;
    for (int f = 0; f < 12; f++) begin
      int  nbits;
      bit  wide;
      bit  joint;
      nbits = int'($urandom_range(100, 1));
      wide  = $urandom_range(1);
      joint = $urandom_range(1);
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < nbits; i++) begin
        int d;
        int t;
        if ($urandom_range(3) == 0) applyStimulus(0, 0, 0, 0, 0);
        d = wide ? int'($urandom) : int'($urandom_range(20)) - 10;
        t = wide ? int'($urandom) : int'($urandom_range(10)) - 5;
        applyStimulus(0, 1, (i == nbits - 1) && joint, d, t);
      end
      if (!joint) applyStimulus(0, 0, 1, 0, 0);
      waitFrame($sformatf("rand%0d", f));
      frameCounts($sformatf("rand%0d", f));
      tick();
    end
    drainWait("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/conv_pack.md
Name: conv_pack

Overview:
- Consumer end of the conv output stream: takes the signed per-pixel results from conv (dout/ovalid/done).
- Binarizes each result against a threshold and packs the bits LSB-first into PACK_W-bit words.
- Buffers the words in a small FIFO and presents them to the next BNN layer or the buffer writer over a valid/ready handshake.
- Absorbs conv's lack of backpressure and flags loss instead of stalling.

Parameters:
- DIN_W, 32, width of signed conv result.
- PACK_W, 32, bits per packed output word.
- FIFO_DEPTH, 4, output word buffer depth (power of two, >=2).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: begin a new frame, clear counters and the overflow flag.
- din  in  DIN_W  signed conv result, driven from conv dout.
- ivalid  in  1  din valid, driven from conv ovalid.
- idone  in  1  end of frame, driven from conv done.
- threshold  in  DIN_W  signed binarization threshold, sampled every ivalid.
- dout  out  PACK_W  packed word at FIFO head.
- ovalid  out  1  dout valid.
- oready  in  1  downstream accepts dout.
- frame_done  out  1  one-cycle pulse when the last word of a frame has been pushed.
- words  out  16  words pushed this frame (saturating).
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (rstn=0 at a clk edge), valid from any state, including mid-frame:
  - FIFO emptied; state IDLE.
  - dout=0, ovalid=0, frame_done=0, words=0, overflow=0.
  - Partial word and bit index cleared.
- Binarize: bit = (signed din >= signed threshold) ? 1 : 0. Full DIN_W signed compare, no truncation.
- States:
  - IDLE: ivalid/idone ignored. start -> PACK.
  - PACK: each ivalid writes its bit into shift[idx] and idx++.
    - When idx reaches PACK_W-1 with ivalid, the completed word is pushed next cycle and idx wraps to 0.
    - idone -> FLUSH.
  - FLUSH:
    - If idx>0, push the partial word with upper bits zero-padded.
    - Then pulse frame_done and -> IDLE.
    - If idx==0, skip the push and pulse frame_done directly.
  - start in any state except IDLE restarts the frame: partial word discarded, words=0, overflow=0. FIFO contents kept.
- Simultaneous ivalid and idone: the bit is packed first, then the flush uses the updated idx. If that bit completes a word, the full word is pushed and no empty pad word follows.
- Latency: last bit of a word -> word at FIFO input 1 cycle -> ovalid 1 cycle later if the FIFO was empty (2 cycles total).
- FIFO:
  - Show-ahead: dout is the head word when ovalid=1, and dout=0 when empty.
  - Pop on ovalid&&oready.
  - Push while full is dropped and overflow set. Pop and push in the same cycle when full is legal: no drop.
- words increments per accepted push and saturates at 16'hFFFF.
- frame_done is high for exactly one cycle, the same cycle as the final push.

Optional Feature:
- Macro: CONV_PACK_POPCNT_EN.
- Defined: adds output port ones (16 bits), the count of 1 bits binarized this frame. It is cleared on start and reset, saturates, and is stable from frame_done until the next start.
- Not defined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package bnn_pkg:
  - localparams DIN_W and PACK_W.
  - State encoding: IDLE=2'd0, PACK=2'd1, FLUSH=2'd2.
- One natural sub-module, bnn_word_fifo: parameterized show-ahead sync FIFO with push/pop/full/empty. It is reusable for the other BNN stages.

Test Plan:
- Basic pack: start, 32 ivalid with din alternating 5/-5, threshold=0, oready=1 -> one word 32'h55555555, words=1, frame_done with idone.
- Partial flush: start, 10 ivalid all din=100, threshold=100, then idone -> word 32'h000003FF, frame_done one cycle.
- Simultaneous ivalid+idone on bit 32 -> exactly one word pushed (no zero pad word), words=1.
- Backpressure: oready=0, push 5 full words with FIFO_DEPTH=4 -> 4 words held, overflow=1. Then oready=1 -> 4 words drain in order, ovalid drops.
- Reset mid-frame after 12 bits -> all outputs 0. Next frame of 32 bits yields a clean word with no leftover bits.
- CONV_PACK_POPCNT_EN defined: 40 bits with 17 ones -> ones=17 at frame_done. Macro undefined: build has no ones port.
